// File: rtl/uart_sdram_cmd_seq.sv
// UART command sequencer. Parses 'W'+addr+data16 / 'R'+addr byte frames,
// issues a single SDRAM access per frame and hands the result to the
// response formatter. Only one command is in flight; rx bytes are
// back-pressured while the sequencer is busy.
module uart_sdram_cmd_seq #(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        rx_data,
  input  logic              rx_stb,
  output logic              rx_ack,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_wdata,
  output logic              sd_wr_req,
  output logic              sd_rd_req,
  input  logic              sd_ack,
  input  logic [15:0]       sd_rdata,
  input  logic              sd_rvalid,
  output logic [15:0]       rsp_data,
  output logic              rsp_stb_rd,
  output logic              rsp_stb_wt,
  input  logic              rsp_ack,
  output logic              busy
);

  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int BC_W       = $clog2(ADDR_BYTES + 1);
  localparam int TO_W       = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, SD_REQ, SD_WAIT, RSP} state_t;

  state_t          state;
  logic            op_wr;
  logic [BC_W-1:0] byte_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic            last_addr;

  // Bytes are only taken while assembling a frame; everything else stalls rx.
  assign rx_ack    = rx_stb & ((state == IDLE) | (state == ADDR) | (state == DATA));
  assign busy      = (state != IDLE);
  assign timeout   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign last_addr = (byte_cnt == BC_W'(ADDR_BYTES - 1));

  // Frame parser, SDRAM handshake and response handshake in one FSM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      op_wr      <= 1'b0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      sd_addr    <= '0;
      sd_wdata   <= '0;
      sd_wr_req  <= 1'b0;
      sd_rd_req  <= 1'b0;
      rsp_data   <= '0;
      rsp_stb_rd <= 1'b0;
      rsp_stb_wt <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_ack && (rx_data == 8'h57 || rx_data == 8'h52)) begin
            op_wr    <= (rx_data == 8'h57);
            byte_cnt <= '0;
            to_cnt   <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (rx_ack) begin
            // Shift MSB-first; whole-byte overflow above ADDR_W falls off the top.
            sd_addr  <= ADDR_W'({sd_addr, rx_data});
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + BC_W'(1);
            if (last_addr) begin
              byte_cnt <= '0;
              state    <= op_wr ? DATA : SD_REQ;
            end
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DATA: begin
          if (rx_ack) begin
            to_cnt <= '0;
            if (byte_cnt == '0) begin
              sd_wdata[15:8] <= rx_data;
              byte_cnt       <= BC_W'(1);
            end else begin
              sd_wdata[7:0] <= rx_data;
              state         <= SD_REQ;
            end
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        SD_REQ: begin
          // First cycle raises the request; sd_ack only counts once it is up.
          if (!sd_wr_req && !sd_rd_req) begin
            sd_wr_req <= op_wr;
            sd_rd_req <= !op_wr;
          end else if (sd_ack) begin
            sd_wr_req <= 1'b0;
            sd_rd_req <= 1'b0;
            if (op_wr) begin
              rsp_data   <= 16'h0000;
              rsp_stb_wt <= 1'b1;
              state      <= RSP;
            end else if (sd_rvalid) begin
              rsp_data   <= sd_rdata;
              rsp_stb_rd <= 1'b1;
              state      <= RSP;
            end else begin
              state <= SD_WAIT;
            end
          end
        end
        SD_WAIT: begin
          if (sd_rvalid) begin
            rsp_data   <= sd_rdata;
            rsp_stb_rd <= 1'b1;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ack) begin
            rsp_stb_rd <= 1'b0;
            rsp_stb_wt <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sdram_cmd_seq.sv
// Bench for uart_sdram_cmd_seq: directed scenarios plus randomized frames
// checked against a byte-stream parsing model and a small SDRAM memory model.
module tb_uart_sdram_cmd_seq;

  localparam int AW = 24;
  localparam int TO = 64;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [7:0]    rx_data;
  logic          rx_stb;
  logic          rx_ack;
  logic [AW-1:0] sd_addr;
  logic [15:0]   sd_wdata;
  logic          sd_wr_req, sd_rd_req, sd_ack;
  logic [15:0]   sd_rdata;
  logic          sd_rvalid;
  logic [15:0]   rsp_data;
  logic          rsp_stb_rd, rsp_stb_wt, rsp_ack, busy;

  int tests = 0;
  int fails = 0;

  typedef logic [7:0] bq_t[$];
  logic [15:0] mem [int];

  uart_sdram_cmd_seq #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .rx_data(rx_data), .rx_stb(rx_stb), .rx_ack(rx_ack),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_wr_req(sd_wr_req), .sd_rd_req(sd_rd_req), .sd_ack(sd_ack),
    .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid),
    .rsp_data(rsp_data), .rsp_stb_rd(rsp_stb_rd), .rsp_stb_wt(rsp_stb_wt),
    .rsp_ack(rsp_ack), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // At most one of the request/strobe outputs may be high at any time.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      tests++;
      if ($countones({sd_wr_req, sd_rd_req, rsp_stb_rd, rsp_stb_wt}) > 1) begin
        fails++;
        $display("FAIL onehot: got %b required at most one set",
                 {sd_wr_req, sd_rd_req, rsp_stb_rd, rsp_stb_wt});
      end
    end
  end

  // Reference parser: first 'W'/'R' starts a frame, then address bytes
  // MSB-first, then two data bytes for writes. Everything before is dropped.
  function automatic void model_parse(input bq_t q, output bit ok, output bit wr,
                                      output logic [AW-1:0] a, output logic [15:0] d);
    int i = 0;
    ok = 0; wr = 0; a = '0; d = '0;
    while (i < q.size() && q[i] != 8'h57 && q[i] != 8'h52) i++;
    if (i >= q.size()) return;
    wr = (q[i] == 8'h57);
    if (q.size() < i + 1 + 3 + (wr ? 2 : 0)) return;
    a = AW'((int'(q[i+1]) * 65536 + int'(q[i+2]) * 256 + int'(q[i+3])) % (1 << AW));
    if (wr) d = {q[i+4], q[i+5]};
    ok = 1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_stb = 1'b1; #1;
    while (rx_ack !== 1'b1 && n < 200) begin @(negedge CLK); #1; n++; end
    tests++;
    if (rx_ack !== 1'b1) begin
      fails++; $display("FAIL rx_ack_wait: got %b required 1 for byte %h", rx_ack, b);
    end
    @(negedge CLK);
    rx_stb = 1'b0;
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  // SDRAM controller + response formatter behaviour for one command.
  task automatic sdram_xact(input bit wr, input logic [AW-1:0] a, input logic [15:0] d,
                            input int ack_dly, input int rv_dly, input int rsp_dly,
                            input bit hold_rx);
    int n = 0;
    logic [15:0] rd;
    while (!(sd_wr_req | sd_rd_req) && n < 50) begin @(negedge CLK); n++; end
    tests++;
    if ({sd_wr_req, sd_rd_req} !== {wr, !wr}) begin
      fails++; $display("FAIL req_kind: got wr=%b rd=%b required wr=%b", sd_wr_req, sd_rd_req, wr);
      return;
    end
    tests++;
    if (sd_addr !== a) begin fails++; $display("FAIL sd_addr: got %h required %h", sd_addr, a); end
    if (wr) begin
      tests++;
      if (sd_wdata !== d) begin fails++; $display("FAIL sd_wdata: got %h required %h", sd_wdata, d); end
      mem[int'(a)] = d;
      rd = 16'h0000;
    end else begin
      rd = mem.exists(int'(a)) ? mem[int'(a)] : d;
    end
    repeat (ack_dly) begin
      @(negedge CLK);
      tests++;
      if ((sd_wr_req | sd_rd_req) !== 1'b1 || (hold_rx && rx_ack !== 1'b0)) begin
        fails++; $display("FAIL req_hold: got req=%b rx_ack=%b required req=1", sd_wr_req | sd_rd_req, rx_ack);
      end
    end
    sd_ack = 1'b1;
    if (!wr && rv_dly == 0) begin sd_rvalid = 1'b1; sd_rdata = rd; end
    @(negedge CLK);
    sd_ack = 1'b0; sd_rvalid = 1'b0; sd_rdata = 16'hxxxx;
    tests++;
    if ((sd_wr_req | sd_rd_req) !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL req_drop: got req=%b busy=%b required req=0 busy=1", sd_wr_req | sd_rd_req, busy);
    end
    if (!wr && rv_dly > 0) begin
      tests++;
      if (rsp_stb_rd !== 1'b0) begin fails++; $display("FAIL early_rsp: got %b required 0", rsp_stb_rd); end
      repeat (rv_dly - 1) @(negedge CLK);
      sd_rvalid = 1'b1; sd_rdata = rd;
      @(negedge CLK);
      sd_rvalid = 1'b0; sd_rdata = 16'hxxxx;
    end
    tests++;
    if ({rsp_stb_wt, rsp_stb_rd} !== {wr, !wr} || rsp_data !== rd) begin
      fails++; $display("FAIL rsp: got wt=%b rd=%b data=%h required wt=%b data=%h",
                        rsp_stb_wt, rsp_stb_rd, rsp_data, wr, rd);
    end
    repeat (rsp_dly) begin
      @(negedge CLK);
      tests++;
      if ((rsp_stb_wt | rsp_stb_rd) !== 1'b1 || rsp_data !== rd || (hold_rx && rx_ack !== 1'b0)) begin
        fails++; $display("FAIL rsp_hold: got stb=%b data=%h rx_ack=%b required stb=1 data=%h",
                          rsp_stb_wt | rsp_stb_rd, rsp_data, rx_ack, rd);
      end
    end
    rsp_ack = 1'b1;
    @(negedge CLK);
    rsp_ack = 1'b0;
    tests++;
    if ((rsp_stb_wt | rsp_stb_rd) !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rsp_done: got stb=%b busy=%b required 0 0", rsp_stb_wt | rsp_stb_rd, busy);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; rx_stb = 1'b0; rx_data = 8'h00; sd_ack = 1'b0; sd_rvalid = 1'b0;
    sd_rdata = 16'h0000; rsp_ack = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    tests++;
    if ({sd_addr, sd_wdata, rsp_data, sd_wr_req, sd_rd_req, rsp_stb_rd, rsp_stb_wt, busy, rx_ack} !== '0) begin
      fails++; $display("FAIL reset_state: got addr=%h wd=%h rsp=%h ctl=%b required all 0", sd_addr, sd_wdata,
                        rsp_data, {sd_wr_req, sd_rd_req, rsp_stb_rd, rsp_stb_wt, busy, rx_ack});
    end
  endtask

  task automatic test_write();
    send_q('{8'h57, 8'h00, 8'h01, 8'h23, 8'hBE, 8'hEF});
    tests++;
    if (sd_wr_req !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL wr_latency1: got req=%b busy=%b required 0 1", sd_wr_req, busy);
    end
    @(negedge CLK);
    tests++;
    if (sd_wr_req !== 1'b1) begin fails++; $display("FAIL wr_latency2: got %b required 1", sd_wr_req); end
    sdram_xact(1'b1, 24'h000123, 16'hBEEF, 3, 0, 0, 1'b0);
  endtask

  task automatic test_read();
    mem[int'(24'h123456)] = 16'hA55A;
    send_q('{8'h52, 8'h12, 8'h34, 8'h56});
    sdram_xact(1'b0, 24'h123456, 16'h0000, 1, 5, 4, 1'b0);
    mem[int'(24'h000200)] = 16'h1357;
    send_q('{8'h52, 8'h00, 8'h02, 8'h00});
    sdram_xact(1'b0, 24'h000200, 16'h0000, 0, 0, 1, 1'b0);
  endtask

  task automatic test_garbage();
    bq_t q = '{8'h00, 8'hFF, 8'h41};
    foreach (q[i]) begin
      send_byte(q[i]);
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL garbage_idle: got busy=%b required 0", busy); end
    end
    mem[7] = 16'h0777;
    send_q('{8'h52, 8'h00, 8'h00, 8'h07});
    sdram_xact(1'b0, 24'h000007, 16'h0000, 2, 1, 0, 1'b0);
    repeat (4) begin
      @(negedge CLK);
      tests++;
      if ((sd_rd_req | sd_wr_req | busy) !== 1'b0) begin
        fails++; $display("FAIL single_read: got req/busy=%b required 0", sd_rd_req | sd_wr_req | busy);
      end
    end
  endtask

  task automatic test_timeout();
    send_q('{8'h57, 8'h00, 8'h00});
    repeat (TO - 1) @(negedge CLK);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL timeout_early: got busy=%b required 1", busy); end
    @(negedge CLK);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL timeout_idle: got busy=%b required 0", busy); end
    mem[int'(24'h00ABCD)] = 16'h4242;
    send_q('{8'h52, 8'h00, 8'hAB, 8'hCD});
    sdram_xact(1'b0, 24'h00ABCD, 16'h0000, 0, 2, 0, 1'b0);
    // A byte arriving in the final counting cycle keeps the frame alive.
    send_q('{8'h57, 8'h00, 8'h00});
    repeat (TO - 1) @(negedge CLK);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL timeout_edge: got busy=%b required 1", busy); end
    send_q('{8'h11, 8'h22, 8'h33});
    sdram_xact(1'b1, 24'h000011, 16'h2233, 1, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    mem[9] = 16'h0909;
    send_q('{8'h52, 8'h00, 8'h00, 8'h09});
    rx_data = 8'h57; rx_stb = 1'b1;
    sdram_xact(1'b0, 24'h000009, 16'h0000, 2, 2, 2, 1'b1);
    tests++;
    if (rx_ack !== 1'b1) begin fails++; $display("FAIL bp_accept: got rx_ack=%b required 1", rx_ack); end
    @(negedge CLK);
    rx_stb = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL bp_frame: got busy=%b required 1", busy); end
    send_q('{8'h00, 8'h00, 8'h0A, 8'hC0, 8'hDE});
    sdram_xact(1'b1, 24'h00000A, 16'hC0DE, 0, 0, 1, 1'b0);
  endtask

  task automatic test_ignore();
    sd_ack = 1'b1; sd_rvalid = 1'b1; rsp_ack = 1'b1;
    repeat (2) @(negedge CLK);
    sd_ack = 1'b0; sd_rvalid = 1'b0; rsp_ack = 1'b0;
    tests++;
    if ({busy, sd_wr_req, sd_rd_req, rsp_stb_rd, rsp_stb_wt} !== '0) begin
      fails++; $display("FAIL ignore_idle: got %b required 0", {busy, sd_wr_req, sd_rd_req, rsp_stb_rd, rsp_stb_wt});
    end
  endtask

  task automatic test_reset_mid();
    send_q('{8'h52, 8'h00, 8'h00, 8'h05});
    @(negedge CLK);
    tests++;
    if (sd_rd_req !== 1'b1) begin fails++; $display("FAIL rst_pre: got %b required 1", sd_rd_req); end
    #2 RST_N = 1'b0;
    #1;
    tests++;
    if ({sd_rd_req, busy} !== 2'b00) begin
      fails++; $display("FAIL rst_async: got req=%b busy=%b required 0 0", sd_rd_req, busy);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    send_q('{8'h57, 8'h00, 8'h00, 8'h05, 8'h55, 8'hAA});
    sdram_xact(1'b1, 24'h000005, 16'h55AA, 1, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      bq_t q;
      bit ok, wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      int ng = $urandom_range(0, 2);
      q = {};
      for (int g = 0; g < ng; g++) begin
        logic [7:0] b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        q.push_back(b);
      end
      q.push_back(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52);
      // Small address pool so reads tend to hit earlier writes.
      q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'($urandom_range(0, 7)));
      if (q[q.size()-4] == 8'h57) begin q.push_back(8'($urandom)); q.push_back(8'($urandom)); end
      model_parse(q, ok, wr, a, d);
      if (!wr) d = 16'($urandom);
      send_q(q);
      sdram_xact(wr, a, d, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_garbage();
    test_ignore();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
